io_responder: RTL and testbench
===============================

Name: io_responder

Overview:
- Device-side responder for the processor's I/O requests: In (read switches), Out and Disp (latch register value to LEDs / 7-seg).
- Gates the processor clock enable while an In instruction waits for a debounced Button press.
- Latches the switch word that the In instruction writes back, and holds the Out/Disp values for the board drivers.
- Sits between the control unit strobes and the board pins, alongside the datapath.

Parameters:
- DATA_WIDTH, 32, width of OutData, InData, OutReg, DispReg.
- SWITCH_WIDTH, 16, width of Switches; must be ≤ DATA_WIDTH.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to change the debounced level (board top sets ~50000).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- In  in  1  current instruction is In (read switches).
- Out  in  1  current instruction is Out.
- Disp  in  1  current instruction is Disp.
- Button  in  1  raw asynchronous push button, active-high (already inverted at board top).
- Switches  in  SWITCH_WIDTH  raw switch inputs.
- OutData  in  DATA_WIDTH  register-file read value for Out/Disp.
- InData  out  DATA_WIDTH  latched switches, zero-extended, for register write-back.
- EnableClock  out  1  processor advance enable (combinational, see below).
- OutReg  out  DATA_WIDTH  value last written by Out.
- DispReg  out  DATA_WIDTH  value last written by Disp.
- OutStrobe  out  1  one-cycle pulse on each Out/Disp latch.

Behaviour:
- Reset (async, immediate):
  - State = IDLE; sync flops, debounce counter, debounced level btn_db all 0.
  - InData, OutReg, DispReg, OutStrobe all 0.
- Synchronizer: Button passes through 2 flops (btn_s). Raw-to-btn_s latency is 2 cycles.
- Debounce:
  - If btn_s == btn_db, counter clears to 0.
  - Otherwise counter increments. When the counter reaches DEBOUNCE_CYCLES-1 while btn_s still differs, btn_db <= btn_s and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_db.
  - press = btn_db rising (registered previous level); release = btn_db falling.
- FSM states: IDLE, WAIT_PRESS, COMMIT, WAIT_RELEASE.
- IDLE:
  - EnableClock = ~In.
  - In & btn_db=0 -> WAIT_PRESS.
  - In & btn_db=1 -> WAIT_RELEASE. A held button is never consumed; a fresh press is required.
  - Button activity without In is ignored.
- WAIT_PRESS:
  - EnableClock = 0.
  - On press: InData <= {zeros, Switches} sampled this cycle (Switches pass a 2-flop synchronizer too; 2-cycle skew is acceptable) -> COMMIT.
- COMMIT:
  - EnableClock = 1 for exactly one cycle; the processor writes InData and advances PC.
  - Always -> WAIT_RELEASE.
- WAIT_RELEASE:
  - EnableClock = ~In, so a back-to-back In stalls.
  - On release -> IDLE. The next cycle, IDLE with In asserted -> WAIT_PRESS.
- InData holds its value until the next COMMIT.
- Out/Disp latching:
  - On a rising edge with EnableClock=1 and Out=1: OutReg <= OutData.
  - With EnableClock=1 and Disp=1: DispReg <= OutData.
  - If both are asserted, both latch.
  - OutStrobe is registered: 1 in the cycle after a latch, otherwise 0.
  - No latching while EnableClock=0.
- Simultaneous In with Out/Disp is illegal; In takes priority and Out/Disp are ignored.
- Reset mid-wait: returns to IDLE with EnableClock = ~In. The pending In restarts.

Test Plan:
- Reset with In=0 -> EnableClock=1, InData=0, OutReg=0, DispReg=0, state IDLE.
- In=1, Switches=16'hA5C3; Button high for 10 cycles after 20 cycles, DEBOUNCE_CYCLES=4:
  - EnableClock=0 until COMMIT.
  - EnableClock=1 for exactly one cycle, about 2+4+1 cycles after the Button edge.
  - InData=32'h0000A5C3.
- Button glitch of 3 cycles during WAIT_PRESS -> no COMMIT; EnableClock stays 0; InData unchanged.
- Two consecutive In instructions, button held after the first COMMIT -> second In stalls until release plus a new press; InData takes the second switch value 16'h0042.
- Out=1, OutData=32'hDEADBEEF, EnableClock=1:
  - OutReg=32'hDEADBEEF next cycle; OutStrobe pulses once.
  - Disp with 32'h7 -> DispReg=7, OutReg unchanged.
- Assert reset while in WAIT_PRESS -> immediate IDLE, InData=0. After reset release with In still 1 -> WAIT_PRESS, EnableClock=0.

Source files
------------

// File: rtl/io_responder.sv
// io_responder: stalls the processor on In until a debounced button press, latches Out/Disp values
module io_responder #(
   parameter int DATA_WIDTH      = 32,
   parameter int SWITCH_WIDTH    = 16,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    In,
   input  logic                    Out,
   input  logic                    Disp,
   input  logic                    Button,
   input  logic [SWITCH_WIDTH-1:0] Switches,
   input  logic [DATA_WIDTH-1:0]   OutData,
   output logic [DATA_WIDTH-1:0]   InData,
   output logic                    EnableClock,
   output logic [DATA_WIDTH-1:0]   OutReg,
   output logic [DATA_WIDTH-1:0]   DispReg,
   output logic                    OutStrobe
);
   localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, WAIT_PRESS, COMMIT, WAIT_RELEASE} state_t;
   state_t                  state_q, state_d;
   logic [1:0]              btn_sync_q;
   logic [SWITCH_WIDTH-1:0] sw_s1_q, sw_s_q;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    btn_db_q, btn_db_d, btn_prev_q;
   logic [DATA_WIDTH-1:0]   in_data_q, in_data_d, out_reg_q, out_reg_d, disp_reg_q, disp_reg_d;
   logic                    strobe_q, strobe_d, press, latch;
   assign press   = btn_db_q & ~btn_prev_q;
   assign InData  = in_data_q;
   assign OutReg  = out_reg_q;
   assign DispReg = disp_reg_q;
   assign OutStrobe = strobe_q;
   // Debounce: the level only follows btn_s after DEBOUNCE_CYCLES consecutive differing samples
   always_comb begin
      cnt_d    = (btn_sync_q[1] == btn_db_q || cnt_q == CMAX) ? '0 : cnt_q + 1'b1;
      btn_db_d = (btn_sync_q[1] != btn_db_q && cnt_q == CMAX) ? btn_sync_q[1] : btn_db_q;
   end
   // Next state, clock enable and switch capture; a held button must be released before it counts again
   always_comb begin
      state_d     = state_q;
      EnableClock = ~In;
      in_data_d   = in_data_q;
      case (state_q)
         IDLE: if (In) state_d = btn_db_q ? WAIT_RELEASE : WAIT_PRESS;
         WAIT_PRESS: begin
            EnableClock = 1'b0;
            if (press) begin
               state_d   = COMMIT;
               in_data_d = DATA_WIDTH'(sw_s_q);
            end
         end
         COMMIT: begin
            EnableClock = 1'b1;
            state_d     = WAIT_RELEASE;
         end
         default: if (!btn_db_q) state_d = IDLE;
      endcase
   end
   // Out/Disp latch only on an advancing cycle; In wins over a simultaneous Out/Disp
   always_comb begin
      latch      = EnableClock & ~In;
      out_reg_d  = (latch & Out) ? OutData : out_reg_q;
      disp_reg_d = (latch & Disp) ? OutData : disp_reg_q;
      strobe_d   = latch & (Out | Disp);
   end
   // State registers, synchronizers and output holding registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         btn_sync_q <= '0;
         sw_s1_q    <= '0;
         sw_s_q     <= '0;
         cnt_q      <= '0;
         btn_db_q   <= 1'b0;
         btn_prev_q <= 1'b0;
         in_data_q  <= '0;
         out_reg_q  <= '0;
         disp_reg_q <= '0;
         strobe_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         btn_sync_q <= {btn_sync_q[0], Button};
         sw_s1_q    <= Switches;
         sw_s_q     <= sw_s1_q;
         cnt_q      <= cnt_d;
         btn_db_q   <= btn_db_d;
         btn_prev_q <= btn_db_q;
         in_data_q  <= in_data_d;
         out_reg_q  <= out_reg_d;
         disp_reg_q <= disp_reg_d;
         strobe_q   <= strobe_d;
      end
   end
endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: scoreboard bench for io_responder with randomized In/Out/Disp traffic
module tb_io_responder;
   logic        clock = 1'b0, reset = 1'b1;
   logic        In = 1'b0, Out = 1'b0, Disp = 1'b0, Button = 1'b0;
   logic [15:0] Switches = '0;
   logic [31:0] OutData = '0;
   logic [31:0] InData, OutReg, DispReg;
   logic        EnableClock, OutStrobe;
   int          vectors = 0, miscompares = 0, commits = 0;
   logic [15:0] in_q[$];
   logic [63:0] out_q[$];
   logic [31:0] m_out = '0, m_disp = '0;
   bit          pending_in = 0;

   io_responder #(.DATA_WIDTH(32), .SWITCH_WIDTH(16), .DEBOUNCE_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .In(In), .Out(Out), .Disp(Disp), .Button(Button),
      .Switches(Switches), .OutData(OutData), .InData(InData), .EnableClock(EnableClock),
      .OutReg(OutReg), .DispReg(DispReg), .OutStrobe(OutStrobe)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         if (In && EnableClock) begin
            commits++;
            if (in_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_commit: InData %h with nothing pending", InData);
            end else chk("commit_indata", {32'd0, InData}, {48'd0, in_q.pop_front()});
         end
         if (OutStrobe) begin
            if (out_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_strobe: OutReg %h DispReg %h", OutReg, DispReg);
            end else chk("out_disp_regs", {OutReg, DispReg}, out_q.pop_front());
         end
      end
   end

   task automatic do_in(input logic [15:0] sw, input bit glitch, input bit b2b);
      int c0, n;
      In = 1'b1;
      Switches = sw;
      Out = 1'($urandom_range(0, 1));
      Disp = 1'($urandom_range(0, 1));
      OutData = $urandom;
      repeat (5) step();
      chk("stall_enable", {63'd0, EnableClock}, 64'd0);
      if (glitch) begin
         c0 = commits;
         Button = 1'b1;
         repeat ($urandom_range(1, 3)) step();
         Button = 1'b0;
         repeat (10) step();
         chk("glitch_no_commit", 64'(commits), 64'(c0));
         chk("glitch_enable", {63'd0, EnableClock}, 64'd0);
      end
      in_q.push_back(sw);
      c0 = commits;
      Button = 1'b1;
      n = 0;
      while (commits == c0 && n < 40) begin
         step();
         n++;
      end
      chk("commit_latency", 64'(n), 64'd8);
      Out = 1'b0;
      Disp = 1'b0;
      In = b2b;
      repeat ($urandom_range(1, 8)) begin
         step();
         if (b2b) chk("held_stall", {63'd0, EnableClock}, 64'd0);
      end
      Button = 1'b0;
      repeat (10) step();
      chk("indata_hold", {32'd0, InData}, {48'd0, sw});
      pending_in = b2b;
   endtask

   task automatic do_out(input logic o, input logic d, input logic [31:0] v);
      Out = o;
      Disp = d;
      OutData = v;
      if (o) m_out = v;
      if (d) m_disp = v;
      if (o | d) out_q.push_back({m_out, m_disp});
      step();
      Out = 1'b0;
      Disp = 1'b0;
      OutData = $urandom;
      repeat (2) step();
   endtask

   initial begin
      repeat (2) step();
      chk("rst_enable", {63'd0, EnableClock}, 64'd1);
      chk("rst_indata", {32'd0, InData}, 64'd0);
      chk("rst_regs", {OutReg, DispReg}, 64'd0);
      chk("rst_strobe", {63'd0, OutStrobe}, 64'd0);
      reset = 1'b0;
      repeat (3) step();
      do_in(16'hA5C3, 1, 0);
      chk("indata_a5c3", {32'd0, InData}, 64'h0000_A5C3);
      do_in(16'h1234, 0, 1);
      do_in(16'h0042, 1, 0);
      chk("indata_0042", {32'd0, InData}, 64'h0000_0042);
      do_out(1, 0, 32'hDEADBEEF);
      chk("outreg_deadbeef", {32'd0, OutReg}, 64'h0000_0000_DEAD_BEEF);
      do_out(0, 1, 32'h7);
      chk("dispreg_7", {OutReg, DispReg}, 64'hDEAD_BEEF_0000_0007);
      do_out(1, 1, $urandom);
      for (int i = 0; i < 25; i++) begin
         if (pending_in || $urandom_range(0, 1)) do_in(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else do_out(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end
      if (pending_in) do_in(16'hBEEF, 0, 0);
      In = 1'b1;
      repeat (5) step();
      #3 reset = 1'b1;
      #1;
      chk("midwait_rst_indata", {32'd0, InData}, 64'd0);
      chk("midwait_rst_regs", {OutReg, DispReg}, 64'd0);
      chk("midwait_rst_enable", {63'd0, EnableClock}, 64'd0);
      m_out = '0;
      m_disp = '0;
      step();
      reset = 1'b0;
      repeat (3) step();
      chk("restart_stall", {63'd0, EnableClock}, 64'd0);
      do_in(16'h5A5A, 0, 0);
      do_out(1, 0, 32'hCAFE_0001);
      chk("in_q_drained", 64'(in_q.size()), 64'd0);
      chk("out_q_drained", 64'(out_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
